// File: rtl/game_state_controller.sv
// game_state_controller: snake game master FSM covering start, play, pause, respawn, loss and win, plus score and lives tracking.
// Optional macro GAME_HIGH_SCORE_EN adds a HIGH_SCORE output holding the best final score seen since reset.
//
// state   | meaning
// START   | idle, waiting for a BTNC press to begin a game
// PLAY    | snake moving; collisions, food and pause are processed
// PAUSE   | frozen; BTNU or BTNC press resumes
// RESPAWN | life lost; timed delay before play resumes
// LOSS    | out of lives; BTNC press returns to START
// WIN     | TARGET_SCORE reached; BTNC press returns to START
module game_state_controller #(
   parameter int LIVES_INIT     = 3,
   parameter int LIVES_W        = 4,
   parameter int SCORE_W        = 8,
   parameter int TARGET_SCORE   = 10,
   parameter int RESPAWN_CYCLES = 50000000
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               BTNC,
   input  logic               BTNU,
   input  logic               LOST,
   input  logic               SCORE_EVENT,
   output logic [2:0]         MSM_STATE,
   output logic [SCORE_W-1:0] SCORE,
   output logic [LIVES_W-1:0] LIVES,
   output logic               GAME_ACTIVE,
`ifdef GAME_HIGH_SCORE_EN
   output logic [SCORE_W-1:0] HIGH_SCORE,
`endif
   output logic               STATE_CHANGE
);

   localparam int CNT_W = (RESPAWN_CYCLES > 2) ? $clog2(RESPAWN_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_START   = 3'd0,
      S_PLAY    = 3'd1,
      S_PAUSE   = 3'd2,
      S_RESPAWN = 3'd3,
      S_LOSS    = 3'd4,
      S_WIN     = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d, score_inc;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               btnc_q, btnu_q;
   logic               btnc_press, btnu_press;
   logic               state_change_q;
`ifdef GAME_HIGH_SCORE_EN
   logic [SCORE_W-1:0] high_score_q, high_score_d;
`endif

   assign btnc_press = BTNC & ~btnc_q;
   assign btnu_press = BTNU & ~btnu_q;
   assign score_inc  = score_q + SCORE_W'(1);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q        <= S_START;
         score_q        <= '0;
         lives_q        <= LIVES_W'(LIVES_INIT);
         cnt_q          <= '0;
         btnc_q         <= 1'b0;
         btnu_q         <= 1'b0;
         state_change_q <= 1'b0;
`ifdef GAME_HIGH_SCORE_EN
         high_score_q   <= '0;
`endif
      end else begin
         state_q        <= state_d;
         score_q        <= score_d;
         lives_q        <= lives_d;
         cnt_q          <= cnt_d;
         btnc_q         <= BTNC;
         btnu_q         <= BTNU;
         state_change_q <= (state_d != state_q);
`ifdef GAME_HIGH_SCORE_EN
         high_score_q   <= high_score_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      lives_d = lives_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_START: begin
            if (btnc_press) begin
               state_d = S_PLAY;
               score_d = '0;
               lives_d = LIVES_W'(LIVES_INIT);
            end
         end
         S_PLAY: begin
            // LOST outranks food, food outranks the pause button
            if (LOST) begin
               if (lives_q <= LIVES_W'(1)) begin
                  state_d = S_LOSS;
                  lives_d = '0;
               end else begin
                  state_d = S_RESPAWN;
                  lives_d = lives_q - LIVES_W'(1);
                  cnt_d   = CNT_W'(RESPAWN_CYCLES - 1);
               end
            end else if (SCORE_EVENT) begin
               if (score_q < SCORE_W'(TARGET_SCORE)) begin
                  score_d = score_inc;
                  if (score_inc == SCORE_W'(TARGET_SCORE))
                     state_d = S_WIN;
               end
            end else if (btnu_press) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (btnu_press || btnc_press)
               state_d = S_PLAY;
         end
         S_RESPAWN: begin
            if (cnt_q == '0)
               state_d = S_PLAY;
            else
               cnt_d = cnt_q - CNT_W'(1);
         end
         S_LOSS, S_WIN: begin
            if (btnc_press)
               state_d = S_START;
         end
         default: state_d = S_START;
      endcase
   end

`ifdef GAME_HIGH_SCORE_EN
   always_comb begin
      high_score_d = high_score_q;
      if (state_q == S_PLAY && (state_d == S_LOSS || state_d == S_WIN) &&
          score_d > high_score_q)
         high_score_d = score_d;
   end
`endif

   always_comb begin
      MSM_STATE    = state_q;
      SCORE        = score_q;
      LIVES        = lives_q;
      GAME_ACTIVE  = (state_q == S_PLAY);
      STATE_CHANGE = state_change_q;
`ifdef GAME_HIGH_SCORE_EN
      HIGH_SCORE   = high_score_q;
`endif
   end

endmodule

// File: tb/tb_game_state_controller.sv
// Scoreboard bench for game_state_controller: directed game scenarios followed by random play, against a rule-level model.
// Build with GAME_HIGH_SCORE_EN defined to also check HIGH_SCORE.
module tb_game_state_controller;

   localparam int LIVES_INIT = 3;
   localparam int LIVES_W    = 4;
   localparam int SCORE_W    = 8;
   localparam int TARGET     = 10;
   localparam int RC         = 4;

   localparam int M_START = 0, M_PLAY = 1, M_PAUSE = 2, M_RESPAWN = 3, M_LOSS = 4, M_WIN = 5;

   logic               CLK = 1'b0;
   logic               RESET = 1'b1;
   logic               BTNC = 1'b0;
   logic               BTNU = 1'b0;
   logic               LOST = 1'b0;
   logic               SCORE_EVENT = 1'b0;
   logic [2:0]         MSM_STATE;
   logic [SCORE_W-1:0] SCORE;
   logic [LIVES_W-1:0] LIVES;
   logic               GAME_ACTIVE;
   logic               STATE_CHANGE;
`ifdef GAME_HIGH_SCORE_EN
   logic [SCORE_W-1:0] HIGH_SCORE;
`endif

   game_state_controller #(
      .LIVES_INIT(LIVES_INIT), .LIVES_W(LIVES_W), .SCORE_W(SCORE_W),
      .TARGET_SCORE(TARGET), .RESPAWN_CYCLES(RC)
   ) dut (
      .CLK(CLK), .RESET(RESET), .BTNC(BTNC), .BTNU(BTNU), .LOST(LOST),
      .SCORE_EVENT(SCORE_EVENT), .MSM_STATE(MSM_STATE), .SCORE(SCORE),
      .LIVES(LIVES), .GAME_ACTIVE(GAME_ACTIVE),
`ifdef GAME_HIGH_SCORE_EN
      .HIGH_SCORE(HIGH_SCORE),
`endif
      .STATE_CHANGE(STATE_CHANGE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int st;
      int sc;
      int lv;
      int act;
      int chg;
      int hs;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // reference game model: plain integers, respawn tracked as cycles still to spend
   int m_state = M_START, m_score = 0, m_lives = LIVES_INIT, m_left = 0, m_hs = 0;
   bit m_c_prev = 0, m_u_prev = 0, m_chg = 0;

   task automatic model_step(input bit r, input bit c, input bit u, input bit l, input bit s);
      int  prev;
      bit  pc, pu;
      exp_t e;
      prev = m_state;
      pc   = c && !m_c_prev;
      pu   = u && !m_u_prev;
      if (r) begin
         m_state = M_START; m_score = 0; m_lives = LIVES_INIT; m_left = 0;
         m_hs = 0; m_c_prev = 0; m_u_prev = 0; m_chg = 0;
      end else begin
         m_c_prev = c;
         m_u_prev = u;
         case (m_state)
            M_START: if (pc) begin m_state = M_PLAY; m_score = 0; m_lives = LIVES_INIT; end
            M_PLAY: begin
               if (l) begin
                  m_lives = m_lives - 1;
                  if (m_lives == 0) m_state = M_LOSS;
                  else begin m_state = M_RESPAWN; m_left = RC; end
               end else if (s) begin
                  if (m_score < TARGET) m_score = m_score + 1;
                  if (m_score == TARGET) m_state = M_WIN;
               end else if (pu) m_state = M_PAUSE;
            end
            M_PAUSE: if (pu || pc) m_state = M_PLAY;
            M_RESPAWN: begin
               m_left = m_left - 1;
               if (m_left == 0) m_state = M_PLAY;
            end
            default: if (pc) m_state = M_START;
         endcase
         if (prev == M_PLAY && (m_state == M_LOSS || m_state == M_WIN) && m_score > m_hs)
            m_hs = m_score;
         m_chg = (m_state != prev);
      end
      e.st = m_state; e.sc = m_score; e.lv = m_lives;
      e.act = (m_state == M_PLAY) ? 1 : 0; e.chg = m_chg ? 1 : 0; e.hs = m_hs;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("MSM_STATE", int'(MSM_STATE), e.st);
            chk("SCORE", int'(SCORE), e.sc);
            chk("LIVES", int'(LIVES), e.lv);
            chk("GAME_ACTIVE", int'(GAME_ACTIVE), e.act);
            chk("STATE_CHANGE", int'(STATE_CHANGE), e.chg);
`ifdef GAME_HIGH_SCORE_EN
            chk("HIGH_SCORE", int'(HIGH_SCORE), e.hs);
`endif
         end
      end
   end

   task automatic cyc(input bit r, input bit c, input bit u, input bit l, input bit s);
      @(negedge CLK);
      RESET = r; BTNC = c; BTNU = u; LOST = l; SCORE_EVENT = s;
      model_step(r, c, u, l, s);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0);
   endtask

   task automatic press_c;
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic lose_game;
      repeat (LIVES_INIT) begin
         cyc(0, 0, 0, 1, 0);
         idle(RC + 2);
      end
   endtask

   task automatic score_n(input int n);
      repeat (n) begin
         cyc(0, 0, 0, 0, 1);
         cyc(0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      // reset and start
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      press_c;
      // two respawns then loss
      repeat (2) begin
         cyc(0, 0, 0, 1, 0);
         idle(RC + 2);
      end
      cyc(0, 0, 0, 1, 0);
      idle(2);
      press_c;
      // score to win, extra food ignored
      press_c;
      score_n(11);
      press_c;
      // held pause button, ignored events while paused, resume
      press_c;
      repeat (20) cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 1);
      idle(2);
      cyc(0, 0, 1, 0, 0);
      idle(2);
      // simultaneous LOST and food with two lives left, then reset mid-respawn
      cyc(0, 0, 0, 1, 0);
      idle(RC + 2);
      cyc(0, 0, 0, 1, 1);
      idle(2);
      cyc(1, 0, 0, 0, 0);
      idle(2);
      // three games for the best-score tracking
      press_c; score_n(4); lose_game; press_c;
      press_c; score_n(2); lose_game; press_c;
      press_c; score_n(10); press_c;
      // random play
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 3) == 0));
      end
      idle(2);
      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge CLK);
      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
